// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit types, output direction encoding and route FSM states.
package noc_pkg;

    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    localparam int unsigned DIR_LOCAL = 0;
    localparam int unsigned DIR_NORTH = 1;
    localparam int unsigned DIR_SOUTH = 2;
    localparam int unsigned DIR_EAST  = 3;
    localparam int unsigned DIR_WEST  = 4;
    localparam int unsigned DIR_ERR   = 5;

    typedef logic [5:0] dir_t;

    localparam dir_t DIR_ERR_VEC = 6'b100000;

    typedef enum logic {
        StIdle,
        StLocked
    } state_e;

endpackage

// File: rtl/route_decode.sv
// Combinational dimension-order route decode of one-hot destination fields against
// this router's mesh coordinate.
module route_decode
    import noc_pkg::*;
#(
    parameter int unsigned MESH_X    = 4,
    parameter int unsigned MESH_Y    = 4,
    parameter int unsigned YX_FIRST  = 0,
    parameter int unsigned ROUTER_ID = 0
) (
    input  logic [MESH_X-1:0] col,
    input  logic [MESH_Y-1:0] row,
    output dir_t              dir
);

    localparam int unsigned OWN_X = ROUTER_ID % MESH_X;
    localparam int unsigned OWN_Y = ROUTER_ID / MESH_X;

    int unsigned dx;
    int unsigned dy;
    dir_t        ew;
    dir_t        ns;

    always_comb begin
        dx = 0;
        dy = 0;
        for (int unsigned i = 0; i < MESH_X; i++) begin
            if (col[i]) dx = i;
        end
        for (int unsigned j = 0; j < MESH_Y; j++) begin
            if (row[j]) dy = j;
        end

        ew = '0;
        ns = '0;
        ew[(dx > OWN_X) ? DIR_EAST : DIR_WEST]   = 1'b1;
        ns[(dy > OWN_Y) ? DIR_NORTH : DIR_SOUTH] = 1'b1;

        dir = '0;
        if (!($onehot(col) && $onehot(row))) begin
            dir = DIR_ERR_VEC;
        end else if (dx == OWN_X && dy == OWN_Y) begin
            dir[DIR_LOCAL] = 1'b1;
        end else if (YX_FIRST == 0) begin
            dir = (dx != OWN_X) ? ew : ns;
        end else begin
            dir = (dy != OWN_Y) ? ns : ew;
        end
    end

endmodule

// File: rtl/route_compute_unit.sv
// Registered route-computation stage: decodes head flits, locks the route for the packet
// body and presents flit plus one-hot direction to the switch allocator one cycle later.
module route_compute_unit
    import noc_pkg::*;
#(
    parameter int unsigned ROUTER_ID = 0,
    parameter int unsigned MESH_X    = 4,
    parameter int unsigned MESH_Y    = 4,
    parameter int unsigned FLIT_W    = 17,
    parameter int unsigned YX_FIRST  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [FLIT_W-1:0] flit_o,
    output logic [5:0]        direction_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              proto_err_o
);

    logic [1:0]        ftype;
    dir_t              dec_dir;
    logic              accept;

    state_e            state_q, state_d;
    dir_t              route_q, route_d;
    dir_t              dir_q, dir_d;
    logic              err_q, err_d;
    logic [FLIT_W-1:0] flit_q;
    logic              valid_q;

    assign ftype = flit_i[FLIT_W-1 -: 2];

    route_decode #(
        .MESH_X    (MESH_X),
        .MESH_Y    (MESH_Y),
        .YX_FIRST  (YX_FIRST),
        .ROUTER_ID (ROUTER_ID)
    ) u_route_decode (
        .col (flit_i[MESH_X-1:0]),
        .row (flit_i[MESH_X+MESH_Y-1:MESH_X]),
        .dir (dec_dir)
    );

    assign ready_o = rst || !valid_q || ready_i;
    assign accept  = valid_i && ready_o && !rst;

    // A head resolved to error locks route_q to error, so its body flits inherit it quietly.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        dir_d   = dec_dir;
        err_d   = 1'b0;
        if (state_q == StIdle) begin
            case (ftype)
                FLIT_HEAD: begin
                    route_d = dec_dir;
                    state_d = StLocked;
                end
                FLIT_SINGLE: ;
                default: begin
                    dir_d = DIR_ERR_VEC;
                    err_d = 1'b1;
                end
            endcase
        end else begin
            case (ftype)
                FLIT_HEAD: begin
                    err_d   = 1'b1;
                    route_d = dec_dir;
                end
                FLIT_SINGLE: begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
                FLIT_TAIL: begin
                    dir_d   = route_q;
                    state_d = StIdle;
                end
                default: dir_d = route_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            route_q <= '0;
            dir_q   <= '0;
            err_q   <= 1'b0;
            flit_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            err_q <= accept && err_d;
            if (accept) begin
                flit_q  <= flit_i;
                dir_q   <= dir_d;
                valid_q <= 1'b1;
                state_q <= state_d;
                route_q <= route_d;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign flit_o      = flit_q;
    assign direction_o = dir_q;
    assign valid_o     = valid_q;
    assign proto_err_o = err_q;

endmodule

// File: tb/tb_route_compute_unit.sv
// Scoreboard bench for route_compute_unit at router 5 of a 4x4 mesh (XY and YX instances).
module tb_route_compute_unit;
    import noc_pkg::*;

    localparam int unsigned FW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] flit_i, flit_o;
    logic          valid_i, ready_o, valid_o, ready_i, proto_err_o;
    logic [5:0]    direction_o;

    logic [FW-1:0] yx_flit_i, yx_flit_o;
    logic          yx_valid_i, yx_ready_o, yx_valid_o, yx_proto_err_o;
    logic          yx_ready_i = 1'b1;
    logic [5:0]    yx_direction_o;

    always #5 clk = ~clk;

    route_compute_unit #(
        .ROUTER_ID (5), .MESH_X (4), .MESH_Y (4), .FLIT_W (FW), .YX_FIRST (0)
    ) dut (
        .clk (clk), .rst (rst), .flit_i (flit_i), .valid_i (valid_i), .ready_o (ready_o),
        .flit_o (flit_o), .direction_o (direction_o), .valid_o (valid_o),
        .ready_i (ready_i), .proto_err_o (proto_err_o)
    );

    route_compute_unit #(
        .ROUTER_ID (5), .MESH_X (4), .MESH_Y (4), .FLIT_W (FW), .YX_FIRST (1)
    ) dut_yx (
        .clk (clk), .rst (rst), .flit_i (yx_flit_i), .valid_i (yx_valid_i),
        .ready_o (yx_ready_o), .flit_o (yx_flit_o), .direction_o (yx_direction_o),
        .valid_o (yx_valid_o), .ready_i (yx_ready_i), .proto_err_o (yx_proto_err_o)
    );

    typedef struct packed {
        logic [FW-1:0] flit;
        logic [5:0]    dir;
        logic          err;
    } exp_t;

    exp_t          sb_q[$];
    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    int            ready_mode = 0;
    logic          pending_fresh = 1'b0;
    logic          model_locked = 1'b0;
    logic [5:0]    model_route = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: router 5 sits at x=1, y=1.
    function automatic logic [5:0] ref_dir(input logic [3:0] col, input logic [3:0] row,
                                           input bit yx);
        int         x, y, dx, dy;
        logic [5:0] ew, ns;
        x  = 5 % 4;
        y  = 5 / 4;
        dx = 0;
        dy = 0;
        if ($countones(col) != 1 || $countones(row) != 1) return 6'b100000;
        for (int i = 0; i < 4; i++) begin
            if (col[i]) dx = i;
            if (row[i]) dy = i;
        end
        ew = (dx > x) ? 6'b001000 : 6'b010000;
        ns = (dy > y) ? 6'b000010 : 6'b000100;
        if (dx == x && dy == y) return 6'b000001;
        if (yx) return (dy != y) ? ns : ew;
        return (dx != x) ? ew : ns;
    endfunction

    function automatic logic [FW-1:0] mk_flit(input logic [1:0] t, input logic [3:0] col,
                                              input logic [3:0] row);
        logic [6:0] pay;
        pay = 7'($urandom);
        return {t, pay, row, col};
    endfunction

    task automatic model_accept(input logic [FW-1:0] f);
        exp_t       e;
        logic [5:0] d;
        d      = ref_dir(f[3:0], f[7:4], 1'b0);
        e.flit = f;
        e.err  = 1'b0;
        e.dir  = d;
        case (f[FW-1 -: 2])
            FLIT_HEAD: begin
                e.err        = model_locked;
                model_route  = d;
                model_locked = 1'b1;
            end
            FLIT_SINGLE: begin
                e.err        = model_locked;
                model_locked = 1'b0;
            end
            default: begin
                if (model_locked) begin
                    e.dir = model_route;
                end else begin
                    e.dir = 6'b100000;
                    e.err = 1'b1;
                end
                if (f[FW-1 -: 2] == FLIT_TAIL) model_locked = 1'b0;
            end
        endcase
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [FW-1:0] f);
        bit done;
        done    = 1'b0;
        flit_i  = f;
        valid_i = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (ready_o) begin
                @(posedge clk);
                #1;
                model_accept(f);
                pending_fresh = 1'b1;
                done = 1'b1;
            end
        end
        if (!done) check_eq("accept_timeout", 32'd0, 32'd1);
        valid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        valid_i = 1'b1;
        flit_i  = mk_flit(FLIT_HEAD, 4'b0100, 4'b0010);
        @(negedge clk);
        check_eq("ready_in_reset", ready_o, 1);
        repeat (2) @(posedge clk);
        #1;
        valid_i       = 1'b0;
        rst           = 1'b0;
        sb_q.delete();
        pending_fresh = 1'b0;
        model_locked  = 1'b0;
        model_route   = '0;
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        check_eq("rst_valid_o", valid_o, 0);
        check_eq("rst_flit_o", flit_o, 0);
        check_eq("rst_direction_o", direction_o, 0);
        check_eq("rst_proto_err_o", proto_err_o, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       ready_i = ~ready_i;
                2:       ready_i = 1'($urandom_range(0, 1));
                default: ready_i = 1'b1;
            endcase
        end
    end

    // Output monitor: compares each freshly loaded flit and checks stalls hold the output.
    initial begin
        exp_t          e;
        logic          exp_valid;
        logic          last_valid = 1'b0;
        logic          last_ready = 1'b0;
        logic [FW-1:0] last_flit = '0;
        logic [5:0]    last_dir = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_valid = 1'b0;
                continue;
            end
            check_eq("ready_o", ready_o, 32'(!valid_o || ready_i));
            if (pending_fresh) begin
                pending_fresh = 1'b0;
                exp_valid     = 1'b1;
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("flit_o", flit_o, e.flit);
                    check_eq("direction_o", direction_o, e.dir);
                    check_eq("proto_err_o", proto_err_o, e.err);
                    last_flit = e.flit;
                    last_dir  = e.dir;
                end
            end else begin
                exp_valid = last_valid && !last_ready;
                check_eq("proto_err_quiet", proto_err_o, 0);
                if (exp_valid) begin
                    check_eq("flit_hold", flit_o, last_flit);
                    check_eq("dir_hold", direction_o, last_dir);
                end
            end
            check_eq("valid_o", valid_o, exp_valid);
            last_valid = exp_valid;
            last_ready = ready_i;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FW-1:0] f;
        logic [3:0]    col, row;
        logic [1:0]    t;
        rst        = 1'b1;
        valid_i    = 1'b0;
        flit_i     = '0;
        yx_valid_i = 1'b0;
        yx_flit_i  = '0;
        do_reset();
        check_reset_values();

        // Single flits, XY order.
        send(mk_flit(FLIT_SINGLE, 4'b0100, 4'b0010));
        send(mk_flit(FLIT_SINGLE, 4'b0010, 4'b1000));
        send(mk_flit(FLIT_SINGLE, 4'b0010, 4'b0010));
        send(mk_flit(FLIT_SINGLE, 4'b0001, 4'b0001));
        idle_cycles(2);

        // Same south-west destination through the YX instance.
        yx_flit_i  = mk_flit(FLIT_SINGLE, 4'b0001, 4'b0001);
        yx_valid_i = 1'b1;
        @(posedge clk);
        #1;
        yx_valid_i = 1'b0;
        @(negedge clk);
        check_eq("yx_valid_o", yx_valid_o, 1);
        check_eq("yx_direction_o", yx_direction_o, ref_dir(4'b0001, 4'b0001, 1'b1));
        check_eq("yx_flit_o", yx_flit_o, yx_flit_i);
        check_eq("yx_proto_err_o", yx_proto_err_o, 0);
        check_eq("yx_ready_o", yx_ready_o, 1);
        @(posedge clk);
        #1;

        // Packet under a toggling ready, then a body in IDLE proves the tail released the lock.
        ready_mode = 1;
        send(mk_flit(FLIT_HEAD, 4'b0100, 4'b0010));
        repeat (3) send(mk_flit(FLIT_BODY, 4'b1111, 4'b0000));
        send(mk_flit(FLIT_TAIL, 4'b0000, 4'b0000));
        send(mk_flit(FLIT_BODY, 4'b0000, 4'b0000));
        ready_mode = 0;
        idle_cycles(3);

        // Invalid destination head locks the packet to error without pulses.
        send(mk_flit(FLIT_HEAD, 4'b0110, 4'b0010));
        send(mk_flit(FLIT_BODY, 4'b0100, 4'b0010));
        send(mk_flit(FLIT_TAIL, 4'b0100, 4'b0010));

        // Stray body in IDLE, then a head interrupting a locked packet.
        send(mk_flit(FLIT_BODY, 4'b0100, 4'b0010));
        send(mk_flit(FLIT_HEAD, 4'b0100, 4'b0010));
        send(mk_flit(FLIT_BODY, 4'b0000, 4'b0000));
        send(mk_flit(FLIT_HEAD, 4'b0010, 4'b1000));
        send(mk_flit(FLIT_BODY, 4'b0000, 4'b0000));
        send(mk_flit(FLIT_TAIL, 4'b0000, 4'b0000));
        idle_cycles(2);

        // Random traffic with random backpressure.
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            t   = 2'($urandom_range(0, 3));
            col = 4'b0001 << $urandom_range(0, 3);
            row = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) col = 4'($urandom);
            f = mk_flit(t, col, row);
            send(f);
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end
        ready_mode = 0;
        idle_cycles(4);
        check_eq("sb_drain_mid", 32'(sb_q.size()), 32'd0);

        // Reset mid-packet.
        send(mk_flit(FLIT_HEAD, 4'b0100, 4'b0010));
        send(mk_flit(FLIT_BODY, 4'b0000, 4'b0000));
        do_reset();
        check_reset_values();
        send(mk_flit(FLIT_BODY, 4'b0000, 4'b0000));
        idle_cycles(4);
        check_eq("sb_drain_end", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/route_compute_unit.md
# route_compute_unit

Parametrised, registered route-computation stage for one input port of a mesh router. It decodes the one-hot destination of each head flit against the router's own mesh coordinate and produces a one-hot output direction (XY or YX dimension order). It locks that direction for the packet's body flits until the tail. It sits between the input buffer and the switch allocator, with valid/ready on both sides and one cycle of latency.

## Interface

Parameters:

- ROUTER_ID, 0, linear router index; x = ROUTER_ID % MESH_X, y = ROUTER_ID / MESH_X
- MESH_X, 4, mesh columns (≥2)
- MESH_Y, 4, mesh rows (≥2)
- FLIT_W, 17, flit width; must be ≥ MESH_X+MESH_Y+2
- YX_FIRST, 0, 0 = XY order (resolve column first), 1 = YX order

Ports (clock and reset first):

- clk  in  1  sole clock; everything on rising edge
- rst  in  1  synchronous, active-high reset
- flit_i  in  FLIT_W  input flit
  - [FLIT_W-1 -: 2] = type: 01 head, 00 body, 10 tail, 11 single (head+tail)
  - head/single [MESH_X-1:0] = destination column, one-hot
  - head/single [MESH_X+MESH_Y-1:MESH_X] = destination row, one-hot
- valid_i  in  1  flit_i valid
- ready_o  out  1  stage can accept
- flit_o  out  FLIT_W  registered copy of accepted flit
- direction_o  out  6  one-hot: [0] local, [1] north, [2] south, [3] east, [4] west, [5] error
- valid_o  out  1  flit_o/direction_o valid
- ready_i  in  1  downstream accepts
- proto_err_o  out  1  one-cycle pulse on protocol violation

## Operation

- Accept when valid_i && ready_o. Transfer out when valid_o && ready_i.
- ready_o = !valid_o || ready_i; this is combinational, and a full-throughput pipe.
- Compare destination column dx against own x, and destination row dy against own y, using one-hot index positions:
  - dx > x → east; dx < x → west
  - dy > y → north; dy < y → south
- XY order: if dx ≠ x, go east or west; otherwise go north or south; if both match, local. YX order swaps the priority.
- Destination is invalid if either one-hot field is zero or has more than one bit set. An invalid destination gives direction 6'b100000 (error).
- FSM:
  - IDLE: head → compute direction, latch it into route_q, go to LOCKED. Single → compute direction, stay IDLE. Body or tail → direction = error, proto_err_o pulses, stay IDLE.
  - LOCKED: body → direction = route_q. Tail → direction = route_q, go to IDLE. Head or single → proto_err_o pulses, then treat it as a fresh head or single (recompute, relatch, or return to IDLE for single).
- A packet whose head resolved to error stays locked to error until its tail. Body flits of that packet carry the error direction and do not pulse proto_err_o.
- State updates only on accepted flits. Stalls (ready_i = 0) hold flit_o, direction_o, valid_o, the state and route_q unchanged.

## Timing

- Latency is one cycle: a flit accepted at edge n appears on flit_o/direction_o with valid_o high after edge n.
- Back-to-back flits sustain one per cycle while ready_i = 1.
- Accept and drain in the same cycle: the output register loads the new flit and valid_o stays high.
- proto_err_o is asserted in the cycle after the offending flit is accepted, aligned with that flit on the outputs.
- Reset values: valid_o 0, flit_o 0, direction_o 0, proto_err_o 0, state IDLE, route_q 0.
- Reset mid-packet abandons the packet; the next flit must be a head.
- ready_o is 1 during reset (valid_o is 0). Flits presented while rst is high are not accepted.

## Structure

- Shared package noc_pkg holds:
  - flit-type constants (FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE)
  - direction bit indices (DIR_LOCAL … DIR_ERR)
  - the 6-bit direction typedef
  - the FSM state enum
- One sub-module: route_decode. It is combinational, parametrised by MESH_X, MESH_Y, YX_FIRST, ROUTER_ID. It does one-hot validity check, one-hot-to-index conversion, comparison, and dimension-order selection. It is reused by the local injection port.
- The top level holds the FSM, route_q, the output register and the handshake.

## Test plan

- ROUTER_ID=5 (x=1, y=1), XY order, single flit with column 0100 and row 0010 → east (6'b001000), one cycle later. Column 0010 and row 1000 → north (6'b000010). Column 0010 and row 0010 → local (6'b000001).
- ROUTER_ID=5, YX_FIRST=1, column 0001 and row 0001 → south (6'b000100). The same flit with XY order → west (6'b010000).
- Packet of head (east), then 3 body, then tail, with ready_i toggling every other cycle → all 5 flits show 6'b001000. No flit is lost or duplicated. FSM is back in IDLE after the tail.
- Head with column 0110 → error (6'b100000). Its body and tail also give error. proto_err_o stays 0.
- Body flit while IDLE → error direction and a one-cycle proto_err_o pulse. A head while LOCKED → pulse, then the new route is used for the following body flits.
- Assert rst after a head and one body flit → outputs go to 0 and state to IDLE. A subsequent body flit gives error plus proto_err_o.
